irq_controller: RTL
===================

Name: irq_controller

Overview:
- Collects up to NSRC external interrupt lines, latches rising edges into a pending register and applies per-source enable masking.
- Presents one interrupt at a time to the processor over the ExtIRQ/ExtIAck handshake, with a fixed-priority source ID.
- Sits between board-level interrupt sources and the top-level processor's ExtIRQ input and ExtIAck output.
- Has a small register-mapped config port for enable, pending, status and software-trigger access.

Parameters:
- N, 64, config data-port width; must be at least NSRC and at least IDW+1.
- NSRC, 8, number of interrupt sources (1..32).
- IDW, $clog2(NSRC) (minimum 1), width of the source ID.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- irq_src  input  NSRC  level inputs from sources, already synchronous to clk; a 0->1 transition is an event.
- cfg_we  input  1  config write strobe.
- cfg_addr  input  2  config register select.
- cfg_wdata  input  N  config write data.
- cfg_rdata  output  N  config read data, combinational from cfg_addr.
- ExtIRQ  output  1  interrupt request to processor.
- irq_id  output  IDW  ID of the source being presented; valid while ExtIRQ=1.
- ExtIAck  input  1  acknowledge from processor.

Behaviour:
- Reset: all of these are cleared to 0 — enable, pending, irq_src_prev, active_id, ExtIRQ and irq_id. FSM goes to IDLE. Reset overrides every other event in the same cycle.
- Edge detect: irq_src_prev <= irq_src each cycle. rise = irq_src & ~irq_src_prev. A source held high produces exactly one event.
- Config map (cfg_addr):
  - 0 ENABLE: read/write; bits [NSRC-1:0] are used.
  - 1 PENDING: read; a write clears each bit written as 1 (W1C).
  - 2 STATUS: read-only; bit0 = busy (FSM not IDLE), bits [IDW:1] = active_id.
  - 3 SWTRIG: a write sets pending bits written as 1; reads return 0.
  - Unused upper bits read as 0. Writes to read-only bits are ignored.
- Pending next-state, per bit: pending | rise | swtrig_set, with W1C clear and handshake clear applied. Any set source (rise or SWTRIG) in the same cycle as any clear wins, so no event is lost.
- Eligible = pending & enable. Priority is fixed: the lowest index wins.
- FSM:
  - IDLE: if eligible != 0, latch active_id = lowest set index and go to REQ. ExtIRQ rises on the next cycle, so there is 1-cycle latency from eligible to ExtIRQ=1.
  - REQ: ExtIRQ=1, irq_id=active_id. When ExtIAck=1: clear pending[active_id], go to WAIT_REL; ExtIRQ=0 from the next cycle.
  - WAIT_REL: ExtIRQ=0. Stay until ExtIAck=0, then go to IDLE. A new request needs at least 1 cycle in IDLE.
- No retraction: once in REQ, ExtIRQ stays high and irq_id stays stable until ack. This holds even if the source is disabled, W1C-cleared, or a higher-priority source becomes pending.
- If pending[active_id] was W1C-cleared during REQ, the ack still completes normally; the clear is a no-op.
- ExtIAck=1 while in IDLE is ignored. IDLE only leaves on eligible != 0, so a stuck-high ack cannot cause a spurious grant.
- A new rising edge on active_id in the same cycle the ack clears it leaves pending set; the set wins.
- Reset mid-handshake (REQ or WAIT_REL): next cycle is IDLE with ExtIRQ=0 and all pending bits lost.

Test Plan:
- Reset, then ENABLE=0x01, pulse irq_src[0] for 1 cycle -> pending=0x01, ExtIRQ=1 with irq_id=0 one cycle after pending sets; ExtIAck=1 -> pending=0x00, ExtIRQ=0; ExtIAck=0 -> STATUS.busy=0.
- ENABLE=0xFF, raise irq_src[5] and irq_src[2] in the same cycle -> irq_id=2 first; after the ack cycle irq_id=5; pending ends at 0x00.
- ENABLE=0x00, pulse irq_src[3] -> pending=0x08, ExtIRQ stays 0; write ENABLE=0x08 -> ExtIRQ=1, irq_id=3 after 1 cycle; hold irq_src[3] high for 10 cycles -> only one event is latched.
- While in REQ for id 1, write ENABLE=0x00 and PENDING W1C=0x02 -> ExtIRQ stays 1, irq_id stays 1 until ack; irq_src[1] rising on the ack cycle -> pending[1]=1 afterwards.
- Write SWTRIG=0x80 with ENABLE=0x80 -> irq_id=7; hold ExtIAck high from IDLE beforehand -> no grant until pending sets, then completes via WAIT_REL when ack drops.
- Assert reset during REQ -> next cycle ExtIRQ=0, cfg_rdata at addr 1 = 0, at addr 2 = 0.

Source files
------------

// File: rtl/irq_controller.sv
// irq_controller: edge-latching, enable-masked, fixed-priority interrupt
// controller that presents one source at a time to a processor over the
// ExtIRQ/ExtIAck four-phase handshake. A small register port gives access
// to ENABLE, PENDING (W1C), STATUS and SWTRIG.
module irq_controller #(
  parameter int N    = 64,
  parameter int NSRC = 8,
  parameter int IDW  = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NSRC-1:0]   irq_src,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [N-1:0]      cfg_wdata,
  output logic [N-1:0]      cfg_rdata,
  output logic              ExtIRQ,
  output logic [IDW-1:0]    irq_id,
  input  logic              ExtIAck
);

  // Handshake FSM encoding
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_REQ      = 2'd1;
  localparam logic [1:0] ST_WAIT_REL = 2'd2;

  // Config register addresses
  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;
  localparam logic [1:0] ADDR_SWTRIG  = 2'd3;

  // Architectural state
  logic [NSRC-1:0] enable_q,   enable_d;
  logic [NSRC-1:0] pending_q,  pending_d;
  logic [NSRC-1:0] src_prev_q;
  logic [IDW-1:0]  active_id_q, active_id_d;
  logic [1:0]      state_q,    state_d;

  // Combinational helpers
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] eligible;
  logic [NSRC-1:0] sw_set;
  logic [NSRC-1:0] w1c_clr;
  logic [NSRC-1:0] ack_clr;
  logic            ack_fire;
  logic [IDW-1:0]  win_id;
  logic [N-1:0]    rdata_mux;

  // Only the low NSRC bits of write data carry meaning; the rest are
  // folded into a deliberately unused net so lint does not flag them.
  generate
    if (N > NSRC) begin : g_wdata_upper
      logic unused_wdata_upper;
      assign unused_wdata_upper = ^cfg_wdata[N-1:NSRC];
    end
  endgenerate

  // A source held high yields exactly one event: only the 0->1 edge counts.
  assign rise     = irq_src & ~src_prev_q;
  assign eligible = pending_q & enable_q;

  // Register-port side effects on the pending vector.
  assign sw_set  = (cfg_we && (cfg_addr == ADDR_SWTRIG))  ? cfg_wdata[NSRC-1:0] : '0;
  assign w1c_clr = (cfg_we && (cfg_addr == ADDR_PENDING)) ? cfg_wdata[NSRC-1:0] : '0;

  // The processor's ack retires the presented source exactly once.
  assign ack_fire = (state_q == ST_REQ) && ExtIAck;

  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_ack_clr
      assign ack_clr[gi] = ack_fire && (active_id_q == IDW'(gi));
    end
  endgenerate

  // Lowest-index eligible source wins; scanning downward lets the lowest
  // index overwrite any higher one found earlier.
  always_comb begin
    win_id = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_id = IDW'(i);
      end
    end
  end

  // Enable register: plain read/write of the low NSRC bits.
  always_comb begin
    enable_d = enable_q;
    if (cfg_we && (cfg_addr == ADDR_ENABLE)) begin
      enable_d = cfg_wdata[NSRC-1:0];
    end
  end

  // Pending next state: clears are applied first so a same-cycle set
  // (hardware edge or software trigger) always survives.
  always_comb begin
    pending_d = (pending_q & ~(w1c_clr | ack_clr)) | rise | sw_set;
  end

  // Handshake FSM: once a source is presented it is never retracted, so
  // REQ only looks at ExtIAck and ignores enable/pending changes.
  always_comb begin
    state_d     = state_q;
    active_id_d = active_id_q;
    case (state_q)
      ST_IDLE: begin
        if (eligible != '0) begin
          active_id_d = win_id;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ExtIAck) begin
          state_d = ST_WAIT_REL;
        end
      end
      ST_WAIT_REL: begin
        if (!ExtIAck) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State update; reset overrides every same-cycle event.
  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q    <= '0;
      pending_q   <= '0;
      src_prev_q  <= '0;
      active_id_q <= '0;
      state_q     <= ST_IDLE;
    end else begin
      enable_q    <= enable_d;
      pending_q   <= pending_d;
      src_prev_q  <= irq_src;
      active_id_q <= active_id_d;
      state_q     <= state_d;
    end
  end

  // Read mux, zero-extended to the port width.
  always_comb begin
    rdata_mux = '0;
    case (cfg_addr)
      ADDR_ENABLE:  rdata_mux[NSRC-1:0] = enable_q;
      ADDR_PENDING: rdata_mux[NSRC-1:0] = pending_q;
      ADDR_STATUS: begin
        rdata_mux[0]     = (state_q != ST_IDLE);
        rdata_mux[IDW:1] = active_id_q;
      end
      default:      rdata_mux = '0;
    endcase
  end

  assign cfg_rdata = rdata_mux;
  assign ExtIRQ    = (state_q == ST_REQ);
  assign irq_id    = active_id_q;

endmodule
